// File: rtl/bp_fe_queue_buffer_if.sv
// Packet and control bundle between the FE queue, the decoupling buffer and the BE issue logic.
// The buffer uses the slave modport; the FE/BE side uses master.
interface bp_fe_queue_buffer_if #(
  parameter int fe_queue_width_p = 128
);
  logic [fe_queue_width_p-1:0] fe_queue_i;
  logic                        fe_queue_v_i;
  logic                        fe_queue_ready_o;
  logic [fe_queue_width_p-1:0] fe_queue_o;
  logic                        fe_queue_v_o;
  logic                        fe_queue_yumi_i;
  logic                        commit_v_i;
  logic                        roll_v_i;
  logic                        clr_v_i;

  modport master (
    output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
    input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, commit_v_i, roll_v_i, clr_v_i,
    output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
  );
endinterface

// File: rtl/bp_fe_queue_buffer.sv
// Circular FE packet buffer with speculative read, commit and rollback.
// Write, read and commit pointers carry an extra wrap bit to tell full from empty.
module bp_fe_queue_buffer #(
  parameter int fe_queue_width_p = 128,
  parameter int els_p            = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_fe_queue_buffer_if.slave   q
);
  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;

  ptr_t wptr, rptr, cptr;
  ptr_t cptr_n, pending;
  logic full, read_empty;
  logic enq, deq, commit;

  logic [fe_queue_width_p-1:0] mem [els_p];

  assign full       = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
                    & (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);
  assign read_empty = (rptr == wptr);
  assign pending    = rptr - cptr;

  assign q.fe_queue_ready_o = ~full & ~reset_i;
  assign q.fe_queue_v_o     = ~read_empty & ~reset_i;
  assign q.fe_queue_o       = mem[rptr[idx_width_lp-1:0]];

  // Uncommitted entries still hold space, so ready only reopens once cptr moves.
  assign enq    = q.fe_queue_v_i & q.fe_queue_ready_o & ~q.clr_v_i;
  assign deq    = q.fe_queue_yumi_i & ~read_empty;
  assign commit = q.commit_v_i & (pending != '0);
  assign cptr_n = cptr + ptr_t'(commit);

  // NOTE: sequential state uses non-blocking assignments so every pointer
  // update in this block sees the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (reset_i || q.clr_v_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      // Roll rewinds to the commit pointer after this cycle's commit.
      if (q.roll_v_i)  rptr <= cptr_n;
      else if (deq)    rptr <= rptr + 1'b1;
      cptr <= cptr_n;
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from the pointers,
  // and a reset-free array maps onto plain RAM/flop arrays without a clear tree.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr[idx_width_lp-1:0]] <= q.fe_queue_i;
  end

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) q.fe_queue_yumi_i |-> q.fe_queue_v_o
  );

  commit_only_when_pending: assert property (
    @(posedge clk_i) disable iff (reset_i) q.commit_v_i |-> (pending != '0)
  ) else $warning("commit_v_i with nothing pending is ignored");
endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer: handshake latency, full, rollback, clear and wrap.
module tb_bp_fe_queue_buffer;
  localparam int w_lp   = 128;
  localparam int els_lp = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_fe_queue_buffer_if #(.fe_queue_width_p(w_lp)) bus ();

  bp_fe_queue_buffer #(.fe_queue_width_p(w_lp), .els_p(els_lp)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .q       (bus.slave)
  );

  task automatic check(input string tag, input logic [w_lp-1:0] obs, input logic [w_lp-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; inputs return to idle #1 after the edge.
  task automatic cyc(input logic v, input logic [w_lp-1:0] d, input logic yumi,
                     input logic commit, input logic roll, input logic clr);
    bus.fe_queue_v_i    = v;
    bus.fe_queue_i      = d;
    bus.fe_queue_yumi_i = yumi;
    bus.commit_v_i      = commit;
    bus.roll_v_i        = roll;
    bus.clr_v_i         = clr;
    @(posedge clk);
    #1;
    bus.fe_queue_v_i    = 1'b0;
    bus.fe_queue_i      = '0;
    bus.fe_queue_yumi_i = 1'b0;
    bus.commit_v_i      = 1'b0;
    bus.roll_v_i        = 1'b0;
    bus.clr_v_i         = 1'b0;
  endtask

  initial begin
    int unread, pend;
    logic [w_lp-1:0] next_exp;
    logic do_yumi, do_commit;

    rst = 1'b1;
    bus.fe_queue_v_i = 1'b0; bus.fe_queue_i = '0; bus.fe_queue_yumi_i = 1'b0;
    bus.commit_v_i = 1'b0; bus.roll_v_i = 1'b0; bus.clr_v_i = 1'b0;

    // Reset
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_ready", bus.fe_queue_ready_o, 0);
    check("rst_v", bus.fe_queue_v_o, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", bus.fe_queue_ready_o, 1);
    check("post_rst_v", bus.fe_queue_v_o, 0);

    // A, B, C back to back with yumi whenever a packet is visible
    cyc(1, 'h11, 0, 0, 0, 0);
    check("lat_a_v", bus.fe_queue_v_o, 1);
    check("lat_a", bus.fe_queue_o, 'h11);
    cyc(1, 'h22, 1, 0, 0, 0);
    check("lat_b", bus.fe_queue_o, 'h22);
    cyc(1, 'h33, 1, 0, 0, 0);
    check("lat_c", bus.fe_queue_o, 'h33);
    cyc(0, 0, 1, 0, 0, 0);
    check("lat_drain_v", bus.fe_queue_v_o, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Fill eight with no commit while reading
    for (int i = 0; i < els_lp; i++) begin
      if (i > 0) check($sformatf("fill_rd%0d", i - 1), bus.fe_queue_o, w_lp'('h40 + i - 1));
      cyc(1, w_lp'('h40 + i), bus.fe_queue_v_o, 0, 0, 0);
    end
    check("full_ready", bus.fe_queue_ready_o, 0);
    check("full_v", bus.fe_queue_v_o, 1);
    check("full_last", bus.fe_queue_o, 'h47);
    cyc(0, 0, 1, 0, 0, 0);
    check("full_read_v", bus.fe_queue_v_o, 0);
    check("full_read_ready", bus.fe_queue_ready_o, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("commit_frees_ready", bus.fe_queue_ready_o, 1);
    repeat (els_lp - 1) cyc(0, 0, 0, 1, 0, 0);

    // Speculative reads, one commit, rollback
    for (int i = 1; i <= 4; i++) cyc(1, w_lp'(i), 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("spec_rd%0d", i), bus.fe_queue_o, w_lp'(i));
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("roll_v", bus.fe_queue_v_o, 1);
    check("roll_data", bus.fe_queue_o, 'h2);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("reread%0d", i), bus.fe_queue_o, w_lp'(i));
      cyc(0, 0, 1, 0, 0, 0);
    end
    check("reread_empty", bus.fe_queue_v_o, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Commit and roll in the same cycle
    for (int i = 5; i <= 7; i++) cyc(1, w_lp'(i), 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("cr_pre", bus.fe_queue_o, 'h7);
    cyc(0, 0, 0, 1, 1, 0);
    check("cr_v", bus.fe_queue_v_o, 1);
    check("cr_data", bus.fe_queue_o, 'h6);
    cyc(0, 0, 1, 0, 0, 0);
    check("cr_next", bus.fe_queue_o, 'h7);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

    // Clear with concurrent enqueue and yumi
    for (int i = 0; i < 5; i++) cyc(1, w_lp'('h50 + i), 0, 0, 0, 0);
    check("clr_pre_v", bus.fe_queue_v_o, 1);
    cyc(1, 'hAA, 1, 0, 0, 1);
    check("clr_v", bus.fe_queue_v_o, 0);
    check("clr_ready", bus.fe_queue_ready_o, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("clr_no_aa", bus.fe_queue_v_o, 0);
    cyc(1, 'hBB, 0, 0, 0, 0);
    check("clr_then_bb", bus.fe_queue_o, 'hBB);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Streaming across pointer wrap
    unread = 0; pend = 0; next_exp = 'h100;
    for (int i = 0; i < 3 * els_lp + els_lp; i++) begin
      check($sformatf("wrap_v%0d", i), bus.fe_queue_v_o, (unread > 0));
      if (unread > 0) check($sformatf("wrap_d%0d", i), bus.fe_queue_o, next_exp);
      do_yumi   = (unread > 0);
      do_commit = (pend > 0);
      cyc((i < 3 * els_lp), w_lp'('h100 + i), do_yumi, do_commit, 0, 0);
      if (do_yumi) next_exp++;
      pend   = pend - int'(do_commit) + int'(do_yumi);
      unread = unread - int'(do_yumi) + int'(i < 3 * els_lp);
    end
    check("wrap_count", next_exp, w_lp'('h100 + 3 * els_lp));
    check("wrap_ready", bus.fe_queue_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
